// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite register master.
package axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int TIMEOUT_CYC_DEF = 256;

endpackage

// File: rtl/axil_reg_master.sv
// Single-outstanding AXI4-Lite initiator for the MAC register bank.
// Optional watchdog abort: define AXIL_REG_MASTER_TIMEOUT_EN.
module axil_reg_master
    import axil_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              aclk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] M_AXI_awaddr,
    output logic              M_AXI_awvalid,
    input  logic              M_AXI_awready,
    output logic [DATA_W-1:0] M_AXI_wdata,
    output logic              M_AXI_wvalid,
    input  logic              M_AXI_wready,
    input  logic              M_AXI_bvalid,
    input  logic [1:0]        M_AXI_bresp,
    output logic              M_AXI_bready,
    output logic [ADDR_W-1:0] M_AXI_araddr,
    output logic              M_AXI_arvalid,
    input  logic              M_AXI_arready,
    input  logic              M_AXI_rvalid,
    input  logic [DATA_W-1:0] M_AXI_rdata,
    input  logic [1:0]        M_AXI_rresp,
    output logic              M_AXI_rready
);

    state_t              state, nstate;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                aw_done, w_done;
    logic                aw_hs, w_hs, accept, in_wait, tmo;

    assign aw_hs   = M_AXI_awvalid && M_AXI_awready;
    assign w_hs    = M_AXI_wvalid && M_AXI_wready;
    assign accept  = cmd_valid && cmd_ready;
    assign in_wait = (state == WR) || (state == WR_RESP) ||
                     (state == RD_ADDR) || (state == RD_DATA);

`ifdef AXIL_REG_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmr;
    logic        to_q;

    // Restarts on every state change, so each wait phase gets its own budget.
    always_ff @(posedge aclk or posedge Reset) begin
        if (Reset)                tmr <= '0;
        else if (state != nstate) tmr <= '0;
        else if (in_wait)         tmr <= tmr + 16'd1;
    end

    assign tmo         = in_wait && (tmr == TMO_LAST);
    assign rsp_timeout = to_q;
`else
    assign tmo         = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge aclk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (cmd_valid) nstate = cmd_wr ? WR : RD_ADDR;
            WR: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) nstate = WR_RESP;
                else if (tmo)                               nstate = RSP;
            end
            WR_RESP: if (M_AXI_bvalid || tmo)  nstate = RSP;
            RD_ADDR: begin
                if (M_AXI_arready) nstate = RD_DATA;
                else if (tmo)      nstate = RSP;
            end
            RD_DATA: if (M_AXI_rvalid || tmo)  nstate = RSP;
            RSP: begin
                // A command waiting during the response hand-off is taken at once.
                if (rsp_ready) nstate = cmd_valid ? (cmd_wr ? WR : RD_ADDR) : IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        M_AXI_awvalid = 1'b0;
        M_AXI_wvalid  = 1'b0;
        M_AXI_bready  = 1'b0;
        M_AXI_arvalid = 1'b0;
        M_AXI_rready  = 1'b0;
        case (state)
            IDLE:    cmd_ready = 1'b1;
            WR: begin
                M_AXI_awvalid = !aw_done;
                M_AXI_wvalid  = !w_done;
            end
            WR_RESP: M_AXI_bready  = 1'b1;
            RD_ADDR: M_AXI_arvalid = 1'b1;
            RD_DATA: M_AXI_rready  = 1'b1;
            RSP: begin
                rsp_valid = 1'b1;
                cmd_ready = rsp_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge Reset) begin
        if (Reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifdef AXIL_REG_MASTER_TIMEOUT_EN
            to_q    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (state == WR) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end

            if (state == WR_RESP && M_AXI_bvalid) begin
                rdata_q <= '0;
                err_q   <= (M_AXI_bresp != RESP_OKAY);
`ifdef AXIL_REG_MASTER_TIMEOUT_EN
                to_q    <= 1'b0;
`endif
            end else if (state == RD_DATA && M_AXI_rvalid) begin
                rdata_q <= M_AXI_rdata;
                err_q   <= (M_AXI_rresp != RESP_OKAY);
`ifdef AXIL_REG_MASTER_TIMEOUT_EN
                to_q    <= 1'b0;
`endif
            end else if (tmo && nstate == RSP) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
`ifdef AXIL_REG_MASTER_TIMEOUT_EN
                to_q    <= 1'b1;
`endif
            end
        end
    end

    assign M_AXI_awaddr = addr_q;
    assign M_AXI_araddr = addr_q;
    assign M_AXI_wdata  = wdata_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;

endmodule

// File: tb/tb_axil_reg_master.sv
// Directed bench for axil_reg_master against a behavioural MAC register slave.
module tb_axil_reg_master;

    logic        aclk = 1'b0;
    logic        Reset;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 aclk = ~aclk;

    axil_reg_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .aclk(aclk), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .M_AXI_awaddr(awaddr), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
        .M_AXI_wdata(wdata), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
        .M_AXI_bvalid(bvalid), .M_AXI_bresp(bresp), .M_AXI_bready(bready),
        .M_AXI_araddr(araddr), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
        .M_AXI_rvalid(rvalid), .M_AXI_rdata(rdata), .M_AXI_rresp(rresp),
        .M_AXI_rready(rready)
    );

    // Slave model: register file with a one-cycle response after ready is seen.
    logic [31:0] mem [0:127];
    int          aw_delay, aw_wait;
    logic        b_en, r_en;
    logic [1:0]  bresp_k, rresp_k;
    logic [6:0]  aw_idx, ar_idx;
    logic [31:0] w_hold;

    assign awready = (aw_wait >= aw_delay);
    assign wready  = 1'b1;
    assign arready = 1'b1;

    always @(posedge aclk or posedge Reset) begin
        if (Reset) begin
            bvalid  <= 1'b0;
            rvalid  <= 1'b0;
            bresp   <= 2'b00;
            rresp   <= 2'b00;
            rdata   <= '0;
            aw_wait <= 0;
            for (int i = 0; i < 128; i++) mem[i] <= '0;
            mem[26] <= 32'h2710;
        end else begin
            if (awvalid && !awready) aw_wait <= aw_wait + 1;
            else                     aw_wait <= 0;
            if (awvalid && awready) aw_idx <= awaddr[8:2];
            if (wvalid && wready)   w_hold <= wdata;
            bvalid <= b_en && bready && !bvalid;
            if (b_en && bready && !bvalid) begin
                mem[aw_idx] <= w_hold;
                bresp       <= bresp_k;
            end
            if (arvalid && arready) ar_idx <= araddr[8:2];
            rvalid <= r_en && rready && !rvalid;
            if (r_en && rready && !rvalid) begin
                rdata <= mem[ar_idx];
                rresp <= rresp_k;
            end
        end
    end

    // Bus activity monitor
    logic        clr_mon;
    int          awv_cyc, wv_cyc, aw_hs_n, w_hs_n, br_cyc, br_phase, aw_unstable;
    logic        bready_d, awv_d;
    logic [31:0] awaddr_d;

    always @(posedge aclk) begin
        if (clr_mon) begin
            awv_cyc <= 0; wv_cyc <= 0; aw_hs_n <= 0; w_hs_n <= 0;
            br_cyc <= 0; br_phase <= 0; aw_unstable <= 0;
            bready_d <= 1'b0; awv_d <= 1'b0;
        end else begin
            if (awvalid) awv_cyc <= awv_cyc + 1;
            if (wvalid)  wv_cyc  <= wv_cyc + 1;
            if (awvalid && awready) aw_hs_n <= aw_hs_n + 1;
            if (wvalid && wready)   w_hs_n  <= w_hs_n + 1;
            if (bready) br_cyc <= br_cyc + 1;
            if (bready && !bready_d) br_phase <= br_phase + 1;
            if (awv_d && awvalid && awaddr != awaddr_d) aw_unstable <= aw_unstable + 1;
            bready_d <= bready;
            awv_d    <= awvalid && !awready;
            awaddr_d <= awaddr;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        clr_mon = 1'b1;
        @(negedge aclk);
        clr_mon = 1'b0;
    endtask

    // Present a command, wait for acceptance, record what the response should be.
    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] x_rdata, input logic x_err, input logic x_to);
        exp_t e;
        int   n = 0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
        #1;
        while (!cmd_ready && n < 200) begin @(negedge aclk); n++; end
        if (n >= 200) chk("cmd accept timeout", 64'(cmd_ready), 64'd1);
        e.rdata = x_rdata; e.err = x_err; e.to = x_to;
        sb.push_back(e);
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    // Wait for the response (latency counted from the accept cycle), compare, consume.
    task automatic recv(input string tag, input int exp_lat);
        exp_t e;
        int   lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge aclk); lat++; end
        chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
        if (exp_lat > 0) chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " bus idle in RSP"}, {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
        rsp_ready = 1'b1;
        #1;
        if (sb.size() == 0) begin
            chk({tag, " unexpected response"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, " rdata"}, 64'(rsp_rdata), 64'(e.rdata));
            chk({tag, " err/timeout"}, {62'd0, rsp_err, rsp_timeout}, {62'd0, e.err, e.to});
        end
        @(negedge aclk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [34:0] snap;
        logic        any_bad;
        int          n;
        exp_t        e;

        Reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; aw_delay = 0; b_en = 1'b1; r_en = 1'b1;
        bresp_k = 2'b00; rresp_k = 2'b00; clr_mon = 1'b1;
        repeat (3) @(negedge aclk);

        chk("reset ctrl", {55'd0, cmd_ready, rsp_valid, rsp_err, rsp_timeout,
                           awvalid, wvalid, bready, arvalid, rready}, 64'h100);
        chk("reset data", 64'(rsp_rdata | awaddr | araddr | wdata), 64'd0);
        Reset = 1'b0;
        @(negedge aclk);
        clr();

        // Plain write, slave ready tied high
        send(1'b1, 32'h00C, 32'h1234, 32'h0, 1'b0, 1'b0);
        recv("wr 0x00C", 4);
        chk("wr 0x00C aw/w handshakes", {aw_hs_n[31:0], w_hs_n[31:0]}, {32'd1, 32'd1});
        chk("wr 0x00C bready phases", 64'(br_phase), 64'd1);
        chk("slave reg3", 64'(mem[3]), 64'h1234);

        // Read of the RX_MAX_LENGTH default
        send(1'b0, 32'h068, 32'h0, 32'h2710, 1'b0, 1'b0);
        recv("rd 0x068", 4);

        // Delayed awready, immediate wready
        clr();
        aw_delay = 3;
        send(1'b1, 32'h010, 32'hA5A5, 32'h0, 1'b0, 1'b0);
        recv("wr slow aw", 0);
        chk("slow aw awvalid cycles", 64'(awv_cyc), 64'd4);
        chk("slow aw wvalid cycles", 64'(wv_cyc), 64'd1);
        chk("slow aw addr stable", 64'(aw_unstable), 64'd0);
        chk("slow aw bready phases", 64'(br_phase), 64'd1);
        aw_delay = 0;

        // Stalled response with a command waiting behind it
        send(1'b0, 32'h010, 32'h0, 32'hA5A5, 1'b0, 1'b0);
        n = 1;
        while (!rsp_valid && n < 100) begin @(negedge aclk); n++; end
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h00C; cmd_wdata = '0;
        snap = {rsp_valid, rsp_err, rsp_timeout, rsp_rdata};
        any_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== snap || cmd_ready !== 1'b0)
                any_bad = 1'b1;
        end
        chk("stall rsp stable, cmd_ready low", 64'(any_bad), 64'd0);
        rsp_ready = 1'b1;
        #1;
        chk("stall cmd_ready with rsp_ready", 64'(cmd_ready), 64'd1);
        e = sb.pop_front();
        chk("stall rdata", 64'(rsp_rdata), 64'(e.rdata));
        e.rdata = 32'h1234; e.err = 1'b0; e.to = 1'b0;
        sb.push_back(e);
        @(negedge aclk);
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        recv("back-to-back rd 0x00C", 4);

        // Error responses
        rresp_k = 2'b10;
        send(1'b0, 32'h00C, 32'h0, 32'h1234, 1'b1, 1'b0);
        recv("rd slverr", 4);
        rresp_k = 2'b00;
        bresp_k = 2'b10;
        send(1'b1, 32'h014, 32'h55, 32'h0, 1'b1, 1'b0);
        recv("wr slverr", 4);
        bresp_k = 2'b00;

`ifdef AXIL_REG_MASTER_TIMEOUT_EN
        // Slave never answers the write
        clr();
        b_en = 1'b0;
        send(1'b1, 32'h020, 32'h1, 32'h0, 1'b1, 1'b1);
        recv("wr timeout", 0);
        chk("timeout WR_RESP cycles", 64'(br_cyc), 64'd16);
        b_en = 1'b1;
`endif

        // Reset while waiting for read data
        r_en = 1'b0;
        send(1'b0, 32'h068, 32'h0, 32'h0, 1'b0, 1'b0);
        n = 0;
        while (!rready && n < 20) begin @(negedge aclk); n++; end
        chk("rd stall reaches RD_DATA", 64'(rready), 64'd1);
        @(negedge aclk);
        Reset = 1'b1;
        #1;
        chk("mid-rd reset ctrl", {55'd0, cmd_ready, rsp_valid, rsp_err, rsp_timeout,
                                  awvalid, wvalid, bready, arvalid, rready}, 64'h100);
        chk("mid-rd reset data", 64'(rsp_rdata | awaddr | araddr | wdata), 64'd0);
        @(negedge aclk);
        Reset = 1'b0;
        r_en  = 1'b1;
        sb.delete();
        any_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            if (rsp_valid !== 1'b0) any_bad = 1'b1;
        end
        chk("no rsp after reset abort", 64'(any_bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
